rcservo_frame_gen: RTL
======================

# rcservo_frame_gen

Multi-channel RC-servo pulse generator for the FPGA peripheral bus, parametrised in channel count, tick rate and pulse limits. Each channel emits one high pulse per programmable frame; pulse widths are double-buffered, with a shadow register per channel loaded into the active set only at frame start, so outputs never glitch mid-pulse. Sits on the same 5-bit-address / 16-bit-data register bus as the other bus peripherals and drives servo pins directly.

## Interface
- NUM_SERVO, 10, channel count; 1..26
- PRESCALE, 50, Clk cycles per tick; 50 at 50 MHz gives a 1 µs tick
- MIN_PW, 500, minimum pulse width, ticks
- MAX_PW, 2500, maximum pulse width, ticks
- DEF_PERIOD, 20000, reset frame period, ticks
- Clk  in  1  system clock, all logic on rising edge
- nReset  in  1  asynchronous, active-low reset
- Addr  in  5  register address
- DataWr  in  16  write data
- DataRd  out  16  read data, combinational from Addr
- En  in  1  chip select
- Wr  in  1  write strobe; a write occurs on Clk edges where En & Wr
- P  out  NUM_SERVO  servo pulse outputs, registered

## Operation
- Register map:
  - 0..NUM_SERVO-1: channel pulse width (shadow).
  - 0x1B: ramp step (see Configuration).
  - 0x1C: frame period.
  - 0x1D: channel enable mask, bits [NUM_SERVO-1:0].
  - 0x1E: status, read-only; bit0 toggles at every frame start.
  - 0x1F: control; bit0 GEN = global enable.
  - Unmapped reads return 0; unmapped writes are ignored.
- Width writes are clamped into [MIN_PW, MAX_PW]. The clamped value is what reads back.
- Period writes below MAX_PW+1 are stored as MAX_PW+1, so a pulse can never fill a whole frame.
- Prescaler counts 0..PRESCALE-1. It emits a one-cycle tick when it wraps.
- Frame counter (16 bit) advances on each tick. It wraps from period-1 to 0.
- Frame start is the tick on which the frame counter becomes 0. At frame start:
  - all shadow widths load into the active widths;
  - the period register loads into the active period;
  - the status bit toggles.
- Channel output: P[i] = GEN & mask[i] & (frame count < active width[i]).
- GEN=0: prescaler and frame counter are held at 0, and all P are 0.
- GEN 0→1: a new frame begins immediately. Shadows are loaded, counting starts from 0, and P goes high 1 cycle after GEN is written.
- Mask bit cleared mid-pulse: that P drops on the next cycle. The other channels are unaffected.
- Width write landing on the same Clk edge as a frame-start load:
  - the active set takes the pre-write shadow value;
  - the new value applies from the following frame.

## Timing
- Reset values:
  - P = 0; DataRd follows Addr;
  - all shadow and active widths = (MIN_PW+MAX_PW)/2;
  - period = DEF_PERIOD; mask = all ones; GEN = 0; ramp step = 0; status = 0;
  - prescaler and frame counters = 0.
- Write-to-readback latency: 1 Clk.
- Write-to-output latency: the next frame start plus 1 Clk.
- P updates 1 Clk after the tick that changes the comparison. Pulse width is exactly width × PRESCALE Clk cycles.
- Frame length is exactly period × PRESCALE Clk cycles.
- Asserting nReset mid-pulse forces P low asynchronously.

## Configuration
- RCSERVO_RAMP_EN defined:
  - register 0x1B holds a 16-bit ramp step; step 0 means unlimited;
  - at each frame start, each active width moves toward its shadow by at most step ticks.
- RCSERVO_RAMP_EN undefined:
  - active widths take shadow values directly;
  - 0x1B reads 0 and writes to it are ignored.

## Structure
- Shared package rcservo_pkg holds:
  - the register address constants (0x1B–0x1F);
  - the 16-bit width type;
  - the clamp function.
- One sub-module, rcservo_channel, instantiated NUM_SERVO times. It contains:
  - the shadow and active width registers;
  - the optional ramp logic;
  - the compare and output flop.
- The top level holds the bus decode, prescaler, frame counter and control registers.

## Test plan
- Reset, then GEN=1, defaults (PRESCALE=50): every P is high for 75000 Clk, and each frame is 1,000,000 Clk.
- Write 100 to channel 0: reads back 500. Write 9000: reads back 2500.
- Write 2000 to channel 3 mid-frame: the current pulse stays 1500 ticks, and the next frame's pulse is 2000 ticks.
- Write period 1000: reads back 2501. Frame length becomes 2501 ticks from the next frame start.
- Mask=0x0001: only P[0] pulses. Clearing GEN mid-pulse drops P[0] in 1 Clk, and re-setting GEN restarts the frame at 0.
- With RCSERVO_RAMP_EN, step 100, width 1500→2000: pulse widths over successive frames are 1600, 1700, 1800, 1900, 2000.

Source files
------------

// File: rtl/rcservo_pkg.sv
// Shared definitions for the RC-servo frame generator: register addresses,
// pulse-width type and the width clamp helper.
package rcservo_pkg;

  typedef logic [15:0] width_t;

  localparam logic [4:0] A_STEP   = 5'h1B;
  localparam logic [4:0] A_PERIOD = 5'h1C;
  localparam logic [4:0] A_MASK   = 5'h1D;
  localparam logic [4:0] A_STATUS = 5'h1E;
  localparam logic [4:0] A_CTRL   = 5'h1F;

  function automatic width_t clamp_pw(input logic [15:0] v, input width_t lo, input width_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/rcservo_channel.sv
// One servo channel: double-buffered pulse width (shadow/active), optional
// per-frame ramp toward the shadow (RCSERVO_RAMP_EN) and the registered output.
module rcservo_channel
  import rcservo_pkg::*;
#(
  parameter int MIN_PW = 500,
  parameter int MAX_PW = 2500
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_wr,
  input  width_t i_wdata,
  input  logic   i_frame_start,
  input  logic   i_en,
  input  width_t i_fcnt,
`ifdef RCSERVO_RAMP_EN
  input  width_t i_step,
`endif
  output width_t o_shadow,
  output logic   o_p
);

  localparam width_t RST_PW = width_t'((MIN_PW + MAX_PW) / 2);

  width_t r_shadow;
  width_t r_active;
  width_t w_next;
  logic   r_p;

  always_comb begin
    w_next = r_shadow;
`ifdef RCSERVO_RAMP_EN
    // Step 0 means no slew limit.
    if (i_step != '0) begin
      if ((r_shadow > r_active) && ((r_shadow - r_active) > i_step))
        w_next = r_active + i_step;
      else if ((r_active > r_shadow) && ((r_active - r_shadow) > i_step))
        w_next = r_active - i_step;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= RST_PW;
      r_active <= RST_PW;
      r_p      <= 1'b0;
    end else begin
      if (i_wr) r_shadow <= i_wdata;
      // A write on the load edge lands in the shadow only; active sees the old value.
      if (i_frame_start) r_active <= w_next;
      r_p <= i_en && (i_fcnt < r_active);
    end
  end

  assign o_shadow = r_shadow;
  assign o_p      = r_p;

endmodule

// File: rtl/rcservo_frame_gen.sv
// Multi-channel RC-servo pulse generator on the 5-bit address / 16-bit data bus.
// Define RCSERVO_RAMP_EN to enable the per-frame ramp step register (0x1B).
module rcservo_frame_gen
  import rcservo_pkg::*;
#(
  parameter int NUM_SERVO  = 10,
  parameter int PRESCALE   = 50,
  parameter int MIN_PW     = 500,
  parameter int MAX_PW     = 2500,
  parameter int DEF_PERIOD = 20000
) (
  input  logic                 Clk,
  input  logic                 nReset,
  input  logic [4:0]           Addr,
  input  logic [15:0]          DataWr,
  output logic [15:0]          DataRd,
  input  logic                 En,
  input  logic                 Wr,
  output logic [NUM_SERVO-1:0] P
);

  localparam int     PRE_W        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int     MASK_WR_BITS = (NUM_SERVO < 16) ? NUM_SERVO : 16;
  localparam width_t MIN_PERIOD   = width_t'(MAX_PW + 1);

  logic [PRE_W-1:0]     r_pre;
  width_t               r_fcnt;
  width_t               r_period;
  width_t               r_act_period;
  logic [NUM_SERVO-1:0] r_mask;
  logic                 r_gen;
  logic                 r_status;
`ifdef RCSERVO_RAMP_EN
  width_t               r_step;
`endif

  logic   w_wr;
  logic   w_gen_rise;
  logic   w_tick;
  logic   w_wrap;
  logic   w_frame_start;
  width_t w_wdata_pw;
  width_t w_shadow [NUM_SERVO];
  logic [15:0] w_mask16;

  assign w_wr          = En & Wr;
  assign w_gen_rise    = w_wr && (Addr == A_CTRL) && DataWr[0] && !r_gen;
  assign w_tick        = r_gen && (r_pre == PRE_W'(PRESCALE - 1));
  assign w_wrap        = w_tick && (r_fcnt >= r_act_period - 16'd1);
  assign w_frame_start = w_gen_rise | w_wrap;
  assign w_wdata_pw    = clamp_pw(DataWr, width_t'(MIN_PW), width_t'(MAX_PW));

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_pre  <= '0;
      r_fcnt <= '0;
    end else if (!r_gen) begin
      // Held at zero while disabled, so enabling always starts a fresh frame.
      r_pre  <= '0;
      r_fcnt <= '0;
    end else if (w_tick) begin
      r_pre  <= '0;
      r_fcnt <= w_wrap ? '0 : r_fcnt + 16'd1;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_period     <= width_t'(DEF_PERIOD);
      r_act_period <= width_t'(DEF_PERIOD);
      r_mask       <= '1;
      r_gen        <= 1'b0;
      r_status     <= 1'b0;
`ifdef RCSERVO_RAMP_EN
      r_step       <= '0;
`endif
    end else begin
      if (w_frame_start) begin
        r_act_period <= r_period;
        r_status     <= ~r_status;
      end
      if (w_wr) begin
        case (Addr)
          A_PERIOD: r_period <= (DataWr < MIN_PERIOD) ? MIN_PERIOD : DataWr;
          // Only the low 16 channels are reachable through the 16-bit bus.
          A_MASK:   for (int i = 0; i < MASK_WR_BITS; i++) r_mask[i] <= DataWr[i];
          A_CTRL:   r_gen <= DataWr[0];
`ifdef RCSERVO_RAMP_EN
          A_STEP:   r_step <= DataWr;
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_mask16 = '0;
    for (int i = 0; i < MASK_WR_BITS; i++) w_mask16[i] = r_mask[i];
  end

  always_comb begin
    DataRd = '0;
    for (int i = 0; i < NUM_SERVO; i++)
      if (Addr == 5'(i)) DataRd = w_shadow[i];
    case (Addr)
      A_PERIOD: DataRd = r_period;
      A_MASK:   DataRd = w_mask16;
      A_STATUS: DataRd = {15'h0, r_status};
      A_CTRL:   DataRd = {15'h0, r_gen};
`ifdef RCSERVO_RAMP_EN
      A_STEP:   DataRd = r_step;
`endif
      default: ;
    endcase
  end

  for (genvar g = 0; g < NUM_SERVO; g++) begin : g_ch
    rcservo_channel #(
      .MIN_PW(MIN_PW),
      .MAX_PW(MAX_PW)
    ) u_ch (
      .i_clk         (Clk),
      .i_rst_n       (nReset),
      .i_wr          (w_wr && (Addr == 5'(g))),
      .i_wdata       (w_wdata_pw),
      .i_frame_start (w_frame_start),
      .i_en          (r_gen & r_mask[g]),
      .i_fcnt        (r_fcnt),
`ifdef RCSERVO_RAMP_EN
      .i_step        (r_step),
`endif
      .o_shadow      (w_shadow[g]),
      .o_p           (P[g])
    );
  end

endmodule
